// File: rtl/ddr_cmd_pkg.sv
// ddr_cmd_pkg: DDR4 command-slot definitions shared by the slot scheduler and
// the command decoder.
//   - Command type encoding carried in slot[2:0].
//   - Slot field offsets: type [2:0], bank [4:3], bg [6:5], addr from bit 7.
//   - CMD_WIDTH (one slot), NUM_SLOTS (slots per word), WDATA_WIDTH (one beat).
package ddr_cmd_pkg;

  localparam int CMD_WIDTH   = 32;
  localparam int NUM_SLOTS   = 4;
  localparam int WDATA_WIDTH = 512;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_PRE = 3'd1,
    CMD_ACT = 3'd2,
    CMD_RD  = 3'd3,
    CMD_WR  = 3'd4,
    CMD_REF = 3'd5,
    CMD_ZQ  = 3'd6
  } cmd_type_e;

  localparam int CMD_TYPE_LSB = 0;
  localparam int CMD_TYPE_W   = 3;
  localparam int CMD_BANK_LSB = 3;
  localparam int CMD_BANK_W   = 2;
  localparam int CMD_BG_LSB   = 5;
  localparam int CMD_BG_W     = 2;
  localparam int CMD_ADDR_LSB = 7;

endpackage : ddr_cmd_pkg

// File: rtl/cmd_slot_scheduler.sv
// cmd_slot_scheduler: places single DDR4 commands into 4-slot decoder words,
// honouring a per-command minimum NOP gap, and attaches one write-data beat to
// the word carrying a WR. One word is produced per clk while enabled.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   enable            scheduling enable (out_valid follows it one cycle later)
//   cmd_in_data/gap   command slot contents and minimum NOP slots before it
//   cmd_in_valid/ready  command handshake (ready = hold empty or issuing)
//   wd_in_data        write-data beat
//   wd_in_valid/ready   beat handshake (ready only while a WR issues)
//   out_data          {wdata[511:0], slot3, slot2, slot1, slot0}
//   out_valid         word valid
//   wd_stall_cnt      saturating count of cycles a WR waited for its beat
//   busy              hold register occupied
module cmd_slot_scheduler
  import ddr_cmd_pkg::*;
#(
  parameter int SLOT_WIDTH  = CMD_WIDTH,
  parameter int WDATA_WIDTH = ddr_cmd_pkg::WDATA_WIDTH,
  parameter int DLY_WIDTH   = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      enable,
  input  logic [SLOT_WIDTH-1:0]                     cmd_in_data,
  input  logic [DLY_WIDTH-1:0]                      cmd_in_gap,
  input  logic                                      cmd_in_valid,
  output logic                                      cmd_in_ready,
  input  logic [WDATA_WIDTH-1:0]                    wd_in_data,
  input  logic                                      wd_in_valid,
  output logic                                      wd_in_ready,
  output logic [NUM_SLOTS*SLOT_WIDTH+WDATA_WIDTH-1:0] out_data,
  output logic                                      out_valid,
  output logic [CNT_WIDTH-1:0]                      wd_stall_cnt,
  output logic                                      busy
);

  localparam int OUT_WIDTH = NUM_SLOTS * SLOT_WIDTH + WDATA_WIDTH;

  function automatic logic [DLY_WIDTH-1:0] sat_sub(input logic [DLY_WIDTH-1:0] a,
                                                   input logic [DLY_WIDTH-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  // Hold register, gap bookkeeping and output registers.
  logic                  hold_valid_q, hold_valid_d;
  logic [SLOT_WIDTH-1:0] hold_cmd_q,   hold_cmd_d;
  logic [DLY_WIDTH-1:0]  hold_gap_q,   hold_gap_d;
  logic [DLY_WIDTH-1:0]  idle_q,       idle_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q,  stall_cnt_d;
  logic [OUT_WIDTH-1:0]  out_data_q,   out_data_d;
  logic                  out_valid_q,  out_valid_d;

  logic                  hold_is_wr;
  logic                  slot_due;
  logic                  issue;
  logic                  wr_stall;
  logic                  accept;
  logic [1:0]            slot_idx;
  logic [DLY_WIDTH:0]    idle_sum;
  logic [DLY_WIDTH-1:0]  idle_inc;
  logic [NUM_SLOTS*SLOT_WIDTH-1:0] slots_w;
  logic [WDATA_WIDTH-1:0]          wdata_w;

  assign hold_is_wr = (hold_cmd_q[CMD_TYPE_LSB +: CMD_TYPE_W] == CMD_WR);
  assign slot_due   = enable && hold_valid_q && (hold_gap_q < DLY_WIDTH'(NUM_SLOTS));
  assign issue      = slot_due && (!hold_is_wr || wd_in_valid);
  assign wr_stall   = slot_due && hold_is_wr && !wd_in_valid;
  assign slot_idx   = hold_gap_q[1:0];

  assign cmd_in_ready = !hold_valid_q || issue;
  assign wd_in_ready  = issue && hold_is_wr;
  assign accept       = cmd_in_valid && cmd_in_ready;

  assign idle_sum = {1'b0, idle_q} + (DLY_WIDTH+1)'(NUM_SLOTS);
  assign idle_inc = idle_sum[DLY_WIDTH] ? '1 : idle_sum[DLY_WIDTH-1:0];

  // Word build: the issued command lands in slot hold_gap[1:0], all else NOP.
  always_comb begin
    slots_w = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (issue && (slot_idx == 2'(i))) begin
        slots_w[i*SLOT_WIDTH +: SLOT_WIDTH] = hold_cmd_q;
      end
    end
    wdata_w = (issue && hold_is_wr) ? wd_in_data : '0;
  end

  always_comb begin
    out_data_d  = {wdata_w, slots_w};
    out_valid_d = enable;

    // idle counts NOP slots after the last issued command up to the end of
    // the current word; a refill subtracts it so hold_gap is relative to
    // slot 0 of the next word.
    if (!enable) begin
      idle_d = idle_q;
    end else if (issue) begin
      idle_d = DLY_WIDTH'(2'd3 - slot_idx);
    end else begin
      idle_d = idle_inc;
    end

    hold_valid_d = hold_valid_q;
    hold_cmd_d   = hold_cmd_q;
    hold_gap_d   = hold_gap_q;
    if (issue) begin
      hold_valid_d = 1'b0;
    end else if (enable && hold_valid_q) begin
      hold_gap_d = sat_sub(hold_gap_q, DLY_WIDTH'(NUM_SLOTS));
    end
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_cmd_d   = cmd_in_data;
      hold_gap_d   = sat_sub(cmd_in_gap, idle_d);
    end

    stall_cnt_d = stall_cnt_q;
    if (wr_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_cmd_q   <= '0;
      hold_gap_q   <= '0;
      idle_q       <= '1;
      stall_cnt_q  <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_cmd_q   <= hold_cmd_d;
      hold_gap_q   <= hold_gap_d;
      idle_q       <= idle_d;
      stall_cnt_q  <= stall_cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign wd_stall_cnt = stall_cnt_q;
  assign busy         = hold_valid_q;

endmodule : cmd_slot_scheduler

// File: tb/tb_cmd_slot_scheduler.sv
// tb_cmd_slot_scheduler: scoreboard bench for cmd_slot_scheduler. Each sent
// command pushes its expected output cycle, slot and beat; every output word is
// compared against the scoreboard head (or all-NOP when nothing is due).
module tb_cmd_slot_scheduler;
  import ddr_cmd_pkg::*;

  localparam int OW = 640;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [31:0]  cmd_in_data;
  logic [7:0]   cmd_in_gap;
  logic         cmd_in_valid;
  logic         cmd_in_ready;
  logic [511:0] wd_in_data;
  logic         wd_in_valid;
  logic         wd_in_ready;
  logic [OW-1:0] out_data;
  logic         out_valid;
  logic [15:0]  wd_stall_cnt;
  logic         busy;

  cmd_slot_scheduler #(
    .SLOT_WIDTH (32),
    .WDATA_WIDTH(512),
    .DLY_WIDTH  (8),
    .CNT_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cmd_in_data (cmd_in_data),
    .cmd_in_gap  (cmd_in_gap),
    .cmd_in_valid(cmd_in_valid),
    .cmd_in_ready(cmd_in_ready),
    .wd_in_data  (wd_in_data),
    .wd_in_valid (wd_in_valid),
    .wd_in_ready (wd_in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .wd_stall_cnt(wd_stall_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int           due;
    int           slot;
    logic [31:0]  cmd;
    logic [511:0] wd;
  } exp_t;

  exp_t sbq[$];
  bit   mon_en = 1'b0;
  int   wd_hs  = 0;

  task automatic push_exp(input int due, input int slot, input logic [31:0] cmd,
                          input logic [511:0] wd);
    exp_t e;
    e.due = due; e.slot = slot; e.cmd = cmd; e.wd = wd;
    sbq.push_back(e);
  endtask

  // Output monitor: one compare per word.
  always @(negedge clk) begin
    if (wd_in_valid && wd_in_ready) wd_hs++;
    if (mon_en) begin
      logic [OW-1:0] e;
      exp_t h;
      e = '0;
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        chk("late_word", OW'(cyc), OW'(sbq[0].due));
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        h = sbq.pop_front();
        e[h.slot*32 +: 32] = h.cmd;
        e[639:128]         = h.wd;
      end
      chk("word", out_data, e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command; acc is the cycle in which valid&&ready held.
  task automatic send(input logic [31:0] d, input logic [7:0] g, output int acc);
    cmd_in_data  = d;
    cmd_in_gap   = g;
    cmd_in_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_in_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("accept_timeout", OW'(0), OW'(1));
    @(posedge clk);
    #1;
    cmd_in_valid = 1'b0;
  endtask

  localparam logic [31:0] C_ACT = 32'h0000_0012;
  localparam logic [31:0] C_RD  = 32'h0000_0083;
  localparam logic [31:0] C_PRE = 32'h0000_0021;
  localparam logic [31:0] C_ZQ  = 32'h0000_0106;
  localparam logic [31:0] C_WR  = 32'h0000_0104;

  initial begin
    int a;
    int hs0;
    logic [511:0] beat;
    beat = {16{32'hA5A5_A5A5}};

    rst = 1'b1; enable = 1'b0;
    cmd_in_data = '0; cmd_in_gap = '0; cmd_in_valid = 1'b0;
    wd_in_data = '0; wd_in_valid = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", OW'(out_valid), OW'(0));
    chk("rst_busy", OW'(busy), OW'(0));
    chk("rst_cmd_ready", OW'(cmd_in_ready), OW'(1));
    chk("rst_wd_ready", OW'(wd_in_ready), OW'(0));
    chk("rst_stall_cnt", OW'(wd_stall_cnt), OW'(0));
    chk("rst_out_data", out_data, '0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Idle enabled: valid all-NOP words.
    enable = 1'b1;
    tick();
    chk("idle_out_valid", OW'(out_valid), OW'(1));
    repeat (5) tick();

    // ACT gap 0 after long idle: slot 0.
    send(C_ACT, 8'd0, a);
    push_exp(a + 2, 0, C_ACT, '0);
    repeat (4) tick();

    // Back-to-back chain: ACT g0 (s0), RD g6 (s3), PRE g0 (s0), ZQ g4 (s1).
    send(C_ACT, 8'd0, a); push_exp(a + 2, 0, C_ACT, '0);
    send(C_RD,  8'd6, a); push_exp(a + 2, 3, C_RD,  '0);
    send(C_PRE, 8'd0, a); push_exp(a + 2, 0, C_PRE, '0);
    send(C_ZQ,  8'd4, a); push_exp(a + 2, 1, C_ZQ,  '0);
    repeat (5) tick();

    // WR waiting three cycles for its beat.
    hs0 = wd_hs;
    wd_in_valid = 1'b0;
    send(C_WR, 8'd0, a);
    chk("wr_busy", OW'(busy), OW'(1));
    chk("wr_stall_ready", OW'(wd_in_ready), OW'(0));
    tick(); tick(); tick();
    chk("wr_stall_cnt3", OW'(wd_stall_cnt), OW'(3));
    wd_in_data = beat; wd_in_valid = 1'b1;
    #1;
    chk("wr_wd_ready", OW'(wd_in_ready), OW'(1));
    push_exp(a + 5, 0, C_WR, beat);
    tick();
    wd_in_valid = 1'b0; wd_in_data = '0;
    chk("wr_busy_clr", OW'(busy), OW'(0));
    repeat (3) tick();
    chk("wr_stall_hold", OW'(wd_stall_cnt), OW'(3));
    chk("wr_one_beat", OW'(wd_hs - hs0), OW'(1));

    // Enable dropped for two cycles while RD gap 9 is held.
    send(C_ACT, 8'd0, a); push_exp(a + 2, 0, C_ACT, '0);
    send(C_RD,  8'd9, a); push_exp(a + 5, 2, C_RD,  '0);
    tick();
    enable = 1'b0;
    tick();
    chk("dis_valid0", OW'(out_valid), OW'(0));
    chk("dis_busy", OW'(busy), OW'(1));
    tick();
    chk("dis_valid1", OW'(out_valid), OW'(0));
    enable = 1'b1;
    tick();
    chk("en_valid", OW'(out_valid), OW'(1));
    repeat (3) tick();

    // Reset during a WR stall drops the WR.
    hs0 = wd_hs;
    wd_in_valid = 1'b0;
    send(C_WR, 8'd0, a);
    tick();
    rst = 1'b1;
    tick();
    chk("rst2_busy", OW'(busy), OW'(0));
    chk("rst2_out_valid", OW'(out_valid), OW'(0));
    chk("rst2_stall_cnt", OW'(wd_stall_cnt), OW'(0));
    chk("rst2_cmd_ready", OW'(cmd_in_ready), OW'(1));
    rst = 1'b0;
    wd_in_data = beat; wd_in_valid = 1'b1;
    #1;
    chk("rst2_wd_ready", OW'(wd_in_ready), OW'(0));
    repeat (6) tick();
    wd_in_valid = 1'b0;
    chk("rst2_no_beat", OW'(wd_hs - hs0), OW'(0));
    chk("rst2_valid_back", OW'(out_valid), OW'(1));

    chk("sb_empty", OW'(sbq.size()), OW'(0));
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_cmd_slot_scheduler

// File: doc/cmd_slot_scheduler.md
Name: cmd_slot_scheduler

Overview:
Sequences a stream of single DDR4 commands into the 640-bit, 4-slot words consumed by the command decoder, one word per clk.
- Each command carries a minimum-NOP-gap field. The block places the command in the correct slot and fills every other slot with NOP (all-zero slot).
- For a WR command, the block attaches one 512-bit write-data beat to the same word.
- It sits between the host command/wdata streams and the decoder's input_data/input_valid.

Parameters:
- SLOT_WIDTH, 32, bits per command slot; slot[2:0] is the command type (NOP=0, PRE=1, ACT=2, RD=3, WR=4, REF=5, ZQ=6).
- NUM_SLOTS, 4, slots per output word (fixed at 4; other values unsupported).
- WDATA_WIDTH, 512, write-data beat width.
- DLY_WIDTH, 8, width of the gap field and the idle counter.
- CNT_WIDTH, 16, width of the stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  scheduling enable.
- cmd_in_data  in  SLOT_WIDTH  command slot contents.
- cmd_in_gap  in  DLY_WIDTH  minimum NOP slots required after the previously issued command.
- cmd_in_valid  in  1  command valid.
- cmd_in_ready  out  1  command accepted when valid&&ready.
- wd_in_data  in  WDATA_WIDTH  write-data beat.
- wd_in_valid  in  1  beat valid.
- wd_in_ready  out  1  beat consumed when valid&&ready.
- out_data  out  NUM_SLOTS*SLOT_WIDTH+WDATA_WIDTH  word to decoder; [127:0] slots (slot i at [32i+:32]), [639:128] wdata.
- out_valid  out  1  word valid.
- wd_stall_cnt  out  CNT_WIDTH  saturating count of cycles a WR was blocked by a missing wdata beat.
- busy  out  1  hold register occupied.

Behaviour:
State:
- hold register: hold_valid, hold_cmd, hold_gap. hold_gap is NOP slots remaining, measured from slot 0 of the word being built.
- idle_slots: NOP slots elapsed since the last issue, saturating at 2^DLY_WIDTH-1.
- wd_stall_cnt.

Issue rule (combinational, per cycle):
- issue = enable && hold_valid && hold_gap<4 && (hold_cmd[2:0]!=WR || wd_in_valid).
- Slot index s = hold_gap[1:0].

Word build:
- Slot s = hold_cmd when issue; every other slot = 0.
- Data field = wd_in_data when issue of a WR; otherwise 0.
- out_data and out_valid are registered. out_valid <= enable. The word built in cycle N appears at cycle N+1.
- enable=0: out_valid=0, out_data=0, no issue, hold_gap and idle_slots frozen.

wd_in_ready = issue && hold_cmd is WR. Exactly one beat is consumed per WR, in the same cycle as the issue.

cmd_in_ready = !hold_valid || issue. Refill in the same cycle as an issue is allowed.

Gap bookkeeping:
- idle_next = issue ? 3-s : sat(idle_slots+4) when enable; otherwise idle_slots.
- On accept: hold_gap <= sat0(cmd_in_gap - idle_next).
- While held without issue and enable=1: hold_gap <= sat0(hold_gap-4).
- Hence gap=0 issues in the first eligible slot. Throughput is at most one command per word; the gap is a minimum and the actual spacing may be larger.

WR stall:
- Condition: hold_valid && enable && hold_gap<4 && WR && !wd_in_valid.
- Effect: the word is all NOP, wd_stall_cnt increments (saturating), hold_gap stays 0, and the block retries every cycle.

Latency: a command accepted at edge N with an effective gap of 0 issues in the word built in cycle N+1, which is visible on out_data at N+2.

Reset (at any time, including mid-stall):
- hold_valid=0; any pending command is dropped.
- idle_slots=max.
- out_data=0, out_valid=0, wd_stall_cnt=0, cmd_in_ready=1 (combinational from hold_valid), wd_in_ready=0, busy=0.
- Beats already in wdata flight upstream are not tracked; upstream must flush them.

A user-supplied NOP command (type 0) is scheduled like any other command and occupies its slot.

Decomposition:
- Shared package ddr_cmd_pkg holds the command-type constants CMD_NOP..CMD_ZQ, the slot field offsets (type [2:0], bank [4:3], bg [6:5], addr from bit 7), and the CMD_WIDTH/WDATA_WIDTH constants, so the decoder and this block share them.
- No sub-module is needed. The gap arithmetic is a local function sat_sub(a,b).

Test Plan:
- Reset, then enable=1 with no commands -> out_valid=1 from cycle 2, out_data all zero every cycle.
- Send ACT (0x0000_0012) gap=0 after a long idle -> appears in slot 0 two cycles after accept; slots 1-3 zero.
- ACT gap=0, then RD gap=6 back-to-back -> ACT at word N slot 0, RD at word N+1 slot 3 (3 + 3 idle slots), NOPs elsewhere.
- WR gap=0 with wd_in_valid low for 3 cycles, then beat 0xA5.. -> three all-NOP words, wd_stall_cnt=3, then WR in slot 0 with data 0xA5.., wd_in_ready pulses once.
- Toggle enable low for 2 cycles while RD gap=9 is held -> out_valid=0 for 2 cycles, and RD still issues after 9 counted idle slots.
- Assert rst while a WR is stalled -> next cycle busy=0, out_valid=0, wd_stall_cnt=0, and no WR is ever emitted.
